// File: rtl/awg_fifo_pkg.sv
// Shared helpers for the AWG waveform FIFO read path: lane arithmetic and
// width sanity checks used at elaboration time.
package awg_fifo_pkg;

    function automatic int lanes(input int data_w, input int out_w);
        return data_w / out_w;
    endfunction

    function automatic bit widths_ok(input int data_w, input int out_w);
        return (out_w > 0) && (data_w >= out_w) && ((data_w % out_w) == 0);
    endfunction

    // A single-lane configuration still needs a one-bit lane register.
    function automatic int lane_idx_w(input int n_lanes);
        return (n_lanes > 1) ? $clog2(n_lanes) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry word buffer between the FIFO read port and the lane downsizer.
// Push and pop may coincide; the caller never pushes into a full buffer.
module fifo_rd_skid_buf #(
    parameter int P_DATA_WIDTH = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [P_DATA_WIDTH-1:0] push_data,
    input  logic                    pop,
    output logic [P_DATA_WIDTH-1:0] head,
    output logic [1:0]              occ
);

    logic [P_DATA_WIDTH-1:0] mem [2];
    logic                    wr_ptr;
    logic                    rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Drains the waveform FIFO read port into a valid/ready beat stream, splitting
// each FIFO word into P_OUT_WIDTH lanes (lane 0 = LSBs) and counting underruns.
module fifo_rd_stream_adapter
    import awg_fifo_pkg::*;
#(
    parameter int P_DATA_WIDTH = 512,
    parameter int P_OUT_WIDTH  = 128,
    parameter int P_CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_DATA_WIDTH-1:0] fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    output logic [P_OUT_WIDTH-1:0]  m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    input  logic                    clr_cnt,
    output logic [P_CNT_WIDTH-1:0]  underrun_cnt,
    output logic                    underrun
);

    localparam int R  = lanes(P_DATA_WIDTH, P_OUT_WIDTH);
    localparam int LW = lane_idx_w(R);

    if (!widths_ok(P_DATA_WIDTH, P_OUT_WIDTH)) begin : g_bad_width
        $error("fifo_rd_stream_adapter: P_OUT_WIDTH must divide P_DATA_WIDTH");
    end

    logic                    inflight;
    logic                    started;
    logic                    handshake;
    logic                    last_lane;
    logic                    pop;
    logic [LW-1:0]           lane;
    logic [1:0]              occ;
    logic [2:0]              pending;
    logic [31:0]             lane_shift;
    logic [P_DATA_WIDTH-1:0] head;

    fifo_rd_skid_buf #(
        .P_DATA_WIDTH(P_DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_data(fifo_dout),
        .pop      (pop),
        .head     (head),
        .occ      (occ)
    );

    assign m_valid    = (occ != 2'd0);
    assign handshake  = m_valid && m_ready;
    assign last_lane  = (lane == LW'(R - 1));
    assign pop        = handshake && last_lane;
    assign lane_shift = 32'(lane) * 32'(P_OUT_WIDTH);
    assign m_data     = P_OUT_WIDTH'(head >> lane_shift);

    // Words already buffered or on their way, minus the one leaving now; a
    // new read is only issued when its data is guaranteed a free slot.
    assign pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = !rst && !fifo_empty && (pending < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            lane     <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (handshake) begin
                lane <= last_lane ? '0 : lane + LW'(1);
            end
        end
    end

    // Starvation only counts once the stream has delivered its first beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started      <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else if (clr_cnt) begin
            started      <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (handshake) begin
                started <= 1'b1;
            end
            if (started && m_ready && !m_valid) begin
                underrun <= 1'b1;
                if (underrun_cnt != '1) begin
                    underrun_cnt <= underrun_cnt + P_CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
